// File: rtl/imm_extend_reg.sv
// Immediate extender with a one-deep valid/ready output register.
// Tracks consumed results and flags accepted reserved modes.
module imm_extend_reg #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int SA_LO = 6,
  parameter int SA_W  = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [IN_W-1:0]  i_num,
  input  logic [2:0]       ExtSel,
  output logic             o_valid,
  input  logic             o_ready,
  output logic [OUT_W-1:0] o_num,
  output logic             o_err,
  output logic [7:0]       o_count
);

  localparam int PAD = OUT_W - IN_W;

  logic [OUT_W-1:0] sa_ext;
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] upper;
  logic [OUT_W-1:0] ext;
  logic             rsv;
  logic             accept;
  logic             take;

  assign zext  = {{PAD{1'b0}}, i_num};
  assign sext  = {{PAD{i_num[IN_W-1]}}, i_num};
  assign upper = {i_num, {PAD{1'b0}}};
  assign rsv   = ExtSel[2] & (|ExtSel[1:0]);

  always_comb begin
    sa_ext = '0;
    sa_ext[SA_W-1:0] = i_num[SA_LO +: SA_W];
  end

  // Reserved codes fall through to sign-extend.
  always_comb begin
    ext = sext;
    unique case (1'b1)
      (ExtSel == 3'b000): ext = sa_ext;
      (ExtSel == 3'b001): ext = zext;
      (ExtSel == 3'b011): ext = upper;
      (ExtSel == 3'b100): ext = sext << 2;
      default:            ext = sext;
    endcase
  end

  assign i_ready = !o_valid || o_ready;
  assign accept  = i_valid && i_ready;
  assign take    = o_valid && o_ready;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      o_valid <= 1'b0;
      o_num   <= '0;
      o_err   <= 1'b0;
      o_count <= '0;
    end else begin
      if (accept) begin
        o_valid <= 1'b1;
        o_num   <= ext;
        if (rsv) o_err <= 1'b1;
      end else if (take) begin
        o_valid <= 1'b0;
      end
      if (take) o_count <= o_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_extend_reg.sv
// Directed bench for imm_extend_reg: mode table at 32/64 bits,
// backpressure hold, streaming, sticky error and reset override.
module tb_imm_extend_reg;

  logic        CLK;
  logic        RST;
  logic        i_valid;
  logic        i_ready;
  logic        i_ready64;
  logic [15:0] i_num;
  logic [2:0]  ExtSel;
  logic        o_valid;
  logic        o_valid64;
  logic        o_ready;
  logic [31:0] o_num;
  logic [63:0] o_num64;
  logic        o_err;
  logic        o_err64;
  logic [7:0]  o_count;
  logic [7:0]  o_count64;

  int checks;
  int failures;

  imm_extend_reg dut (
    .CLK(CLK), .RST(RST),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_num(i_num), .ExtSel(ExtSel),
    .o_valid(o_valid), .o_ready(o_ready),
    .o_num(o_num), .o_err(o_err),
    .o_count(o_count)
  );

  imm_extend_reg #(.IN_W(16), .OUT_W(64)) dut64 (
    .CLK(CLK), .RST(RST),
    .i_valid(i_valid), .i_ready(i_ready64),
    .i_num(i_num), .ExtSel(ExtSel),
    .o_valid(o_valid64), .o_ready(o_ready),
    .o_num(o_num64), .o_err(o_err64),
    .o_count(o_count64)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] num;
    logic [31:0] exp32;
    logic [63:0] exp64;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0;
    i_valid = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    RST = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b0;
    i_num = '0;
    ExtSel = '0;

    vecs[0] = '{3'b000, 16'h8004, 32'h00000000, 64'h0};
    vecs[1] = '{3'b001, 16'h8004, 32'h00008004, 64'h8004};
    vecs[2] = '{3'b010, 16'h8004, 32'hFFFF8004,
                64'hFFFFFFFFFFFF8004};
    vecs[3] = '{3'b011, 16'h8004, 32'h80040000,
                64'h8004000000000000};
    vecs[4] = '{3'b100, 16'h8004, 32'hFFFE0010,
                64'hFFFFFFFFFFFE0010};
    vecs[5] = '{3'b000, 16'h07C0, 32'h0000001F, 64'h1F};

    do_reset();
    @(negedge CLK);
    chk("rst_o_valid", 64'(o_valid), 64'd0);
    chk("rst_o_num", 64'(o_num), 64'd0);
    chk("rst_o_err", 64'(o_err), 64'd0);
    chk("rst_o_count", 64'(o_count), 64'd0);
    chk("rst_i_ready", 64'(i_ready), 64'd1);

    // Mode table on both widths
    o_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_valid = 1'b1;
      i_num = vecs[i].num;
      ExtSel = vecs[i].sel;
      @(negedge CLK);
      i_valid = 1'b0;
      chk($sformatf("mode%0d_valid", i), 64'(o_valid), 64'd1);
      chk($sformatf("mode%0d_num32", i), 64'(o_num),
          64'(vecs[i].exp32));
      chk($sformatf("mode%0d_num64", i), o_num64, vecs[i].exp64);
      chk($sformatf("mode%0d_err", i), 64'(o_err), 64'd0);
    end

    // Backpressure hold
    do_reset();
    o_ready = 1'b0;
    i_valid = 1'b1;
    i_num = 16'h1234;
    ExtSel = 3'b001;
    @(negedge CLK);
    chk("hold_accept", 64'(o_num), 64'h1234);
    for (int i = 0; i < 5; i++) begin
      i_num = 16'hA000 + 16'(i);
      ExtSel = 3'(i);
      @(negedge CLK);
      chk("hold_num", 64'(o_num), 64'h1234);
      chk("hold_valid", 64'(o_valid), 64'd1);
      chk("hold_i_ready", 64'(i_ready), 64'd0);
      chk("hold_count", 64'(o_count), 64'd0);
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    @(negedge CLK);
    chk("hold_count1", 64'(o_count), 64'd1);
    chk("hold_drop_valid", 64'(o_valid), 64'd0);
    chk("hold_keep_num", 64'(o_num), 64'h1234);

    // 300-deep stream
    do_reset();
    o_ready = 1'b1;
    ExtSel = 3'b001;
    for (int k = 0; k <= 300; k++) begin
      if (k > 0) begin
        chk("stream_valid", 64'(o_valid), 64'd1);
        chk("stream_num", 64'(o_num), 64'(k - 1));
      end
      if (k < 300) begin
        i_valid = 1'b1;
        i_num = 16'(k);
      end else begin
        i_valid = 1'b0;
      end
      @(negedge CLK);
    end
    chk("stream_end_valid", 64'(o_valid), 64'd0);
    chk("stream_count", 64'(o_count), 64'd44);

    // Sticky reserved-mode flag
    do_reset();
    o_ready = 1'b1;
    i_valid = 1'b1;
    i_num = 16'hFFFF;
    ExtSel = 3'b110;
    @(negedge CLK);
    chk("rsv_num", 64'(o_num), 64'hFFFFFFFF);
    chk("rsv_err", 64'(o_err), 64'd1);
    chk("rsv_num64", o_num64, 64'hFFFFFFFFFFFFFFFF);
    ExtSel = 3'b001;
    for (int i = 0; i < 10; i++) begin
      i_num = 16'h0100 + 16'(i);
      @(negedge CLK);
      chk("rsv_legal_num", 64'(o_num), 64'(16'h0100 + 16'(i)));
      chk("rsv_sticky", 64'(o_err), 64'd1);
    end

    // Reset overrides a stalled, pending handshake
    o_ready = 1'b0;
    i_num = 16'h5555;
    @(negedge CLK);
    chk("pre_rst_valid", 64'(o_valid), 64'd1);
    chk("pre_rst_count", 64'(o_count != 8'd0), 64'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk("mid_rst_valid", 64'(o_valid), 64'd0);
    chk("mid_rst_num", 64'(o_num), 64'd0);
    chk("mid_rst_err", 64'(o_err), 64'd0);
    chk("mid_rst_count", 64'(o_count), 64'd0);
    chk("mid_rst_i_ready", 64'(i_ready), 64'd1);
    RST = 1'b1;
    i_valid = 1'b0;
    @(negedge CLK);
    chk("post_rst_i_ready", 64'(i_ready), 64'd1);
    chk("post_rst_valid", 64'(o_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
